// File: rtl/q_episode_controller.sv
// rtl/q_episode_controller.sv - Q-learning episode sequencer: Q-table read, Q_max, action latch, env/update handshakes
module q_episode_controller #(
  parameter int ST_W = 6,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [11:0]       total_iteration,
  input  logic [7:0]        max_steps,
  input  logic [ST_W-1:0]   init_state,
  output logic              q_rd_en,
  output logic [ST_W+1:0]   q_rd_addr,
  input  logic [DW-1:0]     q_rd_data,
  output logic [DW-1:0]     ad_in0,
  output logic [DW-1:0]     ad_in1,
  output logic [DW-1:0]     ad_in2,
  output logic [DW-1:0]     ad_in3,
  output logic [DW-1:0]     ad_qmax,
  input  logic [1:0]        ad_act,
  output logic [11:0]       iteration,
  output logic              env_req,
  output logic [ST_W-1:0]   env_state,
  output logic [1:0]        env_act,
  input  logic              env_ack,
  input  logic [ST_W-1:0]   env_next_state,
  input  logic [DW-1:0]     env_reward,
  input  logic              env_terminal,
  output logic              upd_req,
  output logic [ST_W-1:0]   upd_state,
  output logic [1:0]        upd_act,
  output logic [ST_W-1:0]   upd_next_state,
  output logic [DW-1:0]     upd_reward,
  input  logic              upd_ack,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_RDW, S_MAX, S_DECIDE, S_ENV, S_UPD, S_NEXT, S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      k_q, k_d;
  logic [ST_W-1:0] cur_q, cur_d;
  logic [7:0]      step_q, step_d, step_inc;
  logic [11:0]     iter_q, iter_d, iter_inc;
  logic [DW-1:0]   in0_q, in0_d, in1_q, in1_d, in2_q, in2_d, in3_q, in3_d;
  logic [DW-1:0]   qmax_q, qmax_d, m01, m23;
  logic [1:0]      act_q, act_d;
  logic [ST_W-1:0] ns_q, ns_d;
  logic [DW-1:0]   rw_q, rw_d;
  logic            term_q, term_d, ep_end;
  logic            rd_en_q, rd_en_d;
  logic [ST_W+1:0] rd_addr_q, rd_addr_d;
  logic            env_req_q, env_req_d, upd_req_q, upd_req_d;
  logic            busy_q, busy_d, done_q, done_d;

  // every output is a flop; payloads come straight from captured registers
  assign q_rd_en        = rd_en_q;
  assign q_rd_addr      = rd_addr_q;
  assign ad_in0         = in0_q;
  assign ad_in1         = in1_q;
  assign ad_in2         = in2_q;
  assign ad_in3         = in3_q;
  assign ad_qmax        = qmax_q;
  assign iteration      = iter_q;
  assign env_req        = env_req_q;
  assign env_state      = cur_q;
  assign env_act        = act_q;
  assign upd_req        = upd_req_q;
  assign upd_state      = cur_q;
  assign upd_act        = act_q;
  assign upd_next_state = ns_q;
  assign upd_reward     = rw_q;
  assign busy           = busy_q;
  assign done           = done_q;

  // next-state and next-output computation for the episode sequencer
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cur_d     = cur_q;
    step_d    = step_q;
    iter_d    = iter_q;
    in0_d     = in0_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    in3_d     = in3_q;
    qmax_d    = qmax_q;
    act_d     = act_q;
    ns_d      = ns_q;
    rw_d      = rw_q;
    term_d    = term_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    env_req_d = env_req_q;
    upd_req_d = upd_req_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    step_inc  = step_q + 8'd1;
    iter_inc  = iter_q + 12'd1;
    ep_end    = term_q || ((max_steps != 8'd0) && (step_inc == max_steps));
    m01       = ($signed(in0_q) >= $signed(in1_q)) ? in0_q : in1_q;
    m23       = ($signed(in2_q) >= $signed(in3_q)) ? in2_q : in3_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d  = init_state;
          step_d = 8'd0;
          iter_d = 12'd0;
          busy_d = 1'b1;
          if (total_iteration == 12'd0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d   = S_RD;
            k_d       = 2'd0;
            rd_en_d   = 1'b1;
            rd_addr_d = {init_state, 2'd0};
          end
        end
      end
      S_RD: begin
        // data of the previous read arrives one cycle after its strobe
        case (k_q)
          2'd1:    in0_d = q_rd_data;
          2'd2:    in1_d = q_rd_data;
          2'd3:    in2_d = q_rd_data;
          default: ;
        endcase
        if (k_q == 2'd3) begin
          state_d = S_RDW;
        end else begin
          k_d       = k_q + 2'd1;
          rd_en_d   = 1'b1;
          rd_addr_d = {cur_q, k_q + 2'd1};
        end
      end
      S_RDW: begin
        in3_d   = q_rd_data;
        state_d = S_MAX;
      end
      S_MAX: begin
        qmax_d  = ($signed(m01) >= $signed(m23)) ? m01 : m23;
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        act_d     = ad_act;
        env_req_d = 1'b1;
        state_d   = S_ENV;
      end
      S_ENV: begin
        if (env_ack) begin
          ns_d      = env_next_state;
          rw_d      = env_reward;
          term_d    = env_terminal;
          env_req_d = 1'b0;
          upd_req_d = 1'b1;
          state_d   = S_UPD;
        end
      end
      S_UPD: begin
        if (upd_ack) begin
          upd_req_d = 1'b0;
          state_d   = S_NEXT;
        end
      end
      S_NEXT: begin
        step_d = step_inc;
        if (!ep_end) begin
          cur_d     = ns_q;
          state_d   = S_RD;
          k_d       = 2'd0;
          rd_en_d   = 1'b1;
          rd_addr_d = {ns_q, 2'd0};
        end else begin
          iter_d = iter_inc;
          step_d = 8'd0;
          cur_d  = init_state;
          if (iter_inc >= total_iteration) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d   = S_RD;
            k_d       = 2'd0;
            rd_en_d   = 1'b1;
            rd_addr_d = {init_state, 2'd0};
          end
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // single state register; reset abandons any pending handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      cur_q     <= '0;
      step_q    <= '0;
      iter_q    <= '0;
      in0_q     <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      in3_q     <= '0;
      qmax_q    <= '0;
      act_q     <= '0;
      ns_q      <= '0;
      rw_q      <= '0;
      term_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      env_req_q <= 1'b0;
      upd_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cur_q     <= cur_d;
      step_q    <= step_d;
      iter_q    <= iter_d;
      in0_q     <= in0_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      in3_q     <= in3_d;
      qmax_q    <= qmax_d;
      act_q     <= act_d;
      ns_q      <= ns_d;
      rw_q      <= rw_d;
      term_q    <= term_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      env_req_q <= env_req_d;
      upd_req_q <= upd_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_q_episode_controller.sv
// tb/tb_q_episode_controller.sv - self-checking bench for q_episode_controller
module tb_q_episode_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] total_iteration;
  logic [7:0]  max_steps;
  logic [5:0]  init_state;
  logic        q_rd_en;
  logic [7:0]  q_rd_addr;
  logic [31:0] q_rd_data;
  logic [31:0] ad_in0, ad_in1, ad_in2, ad_in3, ad_qmax;
  logic [1:0]  ad_act;
  logic [11:0] iteration;
  logic        env_req;
  logic [5:0]  env_state;
  logic [1:0]  env_act;
  logic        env_ack;
  logic [5:0]  env_next_state;
  logic [31:0] env_reward;
  logic        env_terminal;
  logic        upd_req;
  logic [5:0]  upd_state;
  logic [1:0]  upd_act;
  logic [5:0]  upd_next_state;
  logic [31:0] upd_reward;
  logic        upd_ack;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  int env_hs = 0;
  int done_cnt = 0;
  logic [31:0] qtab [256];

  q_episode_controller #(.ST_W(6), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .total_iteration(total_iteration), .max_steps(max_steps), .init_state(init_state),
    .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data),
    .ad_in0(ad_in0), .ad_in1(ad_in1), .ad_in2(ad_in2), .ad_in3(ad_in3),
    .ad_qmax(ad_qmax), .ad_act(ad_act), .iteration(iteration),
    .env_req(env_req), .env_state(env_state), .env_act(env_act), .env_ack(env_ack),
    .env_next_state(env_next_state), .env_reward(env_reward), .env_terminal(env_terminal),
    .upd_req(upd_req), .upd_state(upd_state), .upd_act(upd_act),
    .upd_next_state(upd_next_state), .upd_reward(upd_reward), .upd_ack(upd_ack),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Q-table memory: one-cycle read latency, garbage when not strobed
  always @(posedge clk) q_rd_data <= q_rd_en ? qtab[q_rd_addr] : $urandom;

  always @(posedge clk) begin
    if (rst_n && env_req && env_ack) env_hs <= env_hs + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one agent step, entered at a negedge before/at RD entry, left at the NEXT-cycle negedge
  task automatic do_step(input logic [5:0] s, input int ep, input bit term,
                         input int dmin, input int dmax, output logic [5:0] ns);
    int n;
    logic [1:0]  a;
    logic [31:0] q [4];
    logic [31:0] mx;
    logic [31:0] rw;
    logic [7:0]  ea;
    n = 0;
    while (q_rd_en !== 1'b1 && n < 50) begin
      ad_act = 2'($urandom);
      @(negedge clk);
      n++;
    end
    chk("rd_start", q_rd_en, 1);
    chk("iter_at_step", iteration, ep);
    for (int k = 0; k < 4; k++) begin
      ea = {s, 2'(k)};
      q[k] = qtab[ea];
      chk("rd_en", q_rd_en, 1);
      chk("rd_addr", q_rd_addr, ea);
      ad_act = 2'($urandom);
      if (k == 2) env_ack = 1'b1;
      @(negedge clk);
      env_ack = 1'b0;
    end
    chk("rd_en_off", q_rd_en, 0);
    ad_act = 2'($urandom);
    @(negedge clk);
    chk("ad_in0", ad_in0, q[0]);
    chk("ad_in1", ad_in1, q[1]);
    chk("ad_in2", ad_in2, q[2]);
    chk("ad_in3", ad_in3, q[3]);
    mx = q[0];
    for (int k = 1; k < 4; k++) if ($signed(q[k]) > $signed(mx)) mx = q[k];
    ad_act = 2'($urandom);
    @(negedge clk);
    chk("ad_qmax", ad_qmax, mx);
    chk("env_req_early", env_req, 0);
    a = 2'($urandom);
    ad_act = a;
    @(negedge clk);
    ad_act = 2'($urandom);
    chk("env_req_rise", env_req, 1);
    chk("env_state", env_state, s);
    chk("env_act", env_act, a);
    n = $urandom_range(dmax, dmin);
    repeat (n) begin
      @(negedge clk);
      ad_act = 2'($urandom);
      chk("env_req_hold", env_req, 1);
      chk("env_state_hold", env_state, s);
      chk("env_act_hold", env_act, a);
    end
    ns = 6'($urandom);
    rw = $urandom;
    env_next_state = ns;
    env_reward = rw;
    env_terminal = term;
    env_ack = 1'b1;
    @(negedge clk);
    env_ack = 1'b0;
    env_next_state = 6'($urandom);
    env_reward = $urandom;
    env_terminal = ~term;
    chk("env_req_drop", env_req, 0);
    chk("upd_req_rise", upd_req, 1);
    chk("upd_state", upd_state, s);
    chk("upd_act", upd_act, a);
    chk("upd_next_state", upd_next_state, ns);
    chk("upd_reward", upd_reward, rw);
    n = $urandom_range(dmax, dmin);
    repeat (n) begin
      env_ack = 1'($urandom);
      @(negedge clk);
      env_ack = 1'b0;
      chk("upd_req_hold", upd_req, 1);
      chk("upd_next_hold", upd_next_state, ns);
      chk("upd_reward_hold", upd_reward, rw);
      chk("env_req_low", env_req, 0);
    end
    upd_ack = 1'b1;
    @(negedge clk);
    upd_ack = 1'b0;
    chk("upd_req_drop", upd_req, 0);
  endtask

  // a full training run computed from the episode rules
  task automatic run(input int tot, input int maxs, input logic [5:0] init, input int term_at,
                     input int term_pct, input int dmin, input int dmax, input bit poke);
    int stp, nsteps, hs0, dn0;
    logic [5:0] s, ns;
    bit term, ep_end;
    hs0 = env_hs;
    dn0 = done_cnt;
    nsteps = 0;
    total_iteration = 12'(tot);
    max_steps = 8'(maxs);
    init_state = init;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (tot == 0) begin
      chk("zero_done", done, 1);
      chk("zero_rd_en", q_rd_en, 0);
      chk("zero_iter", iteration, 0);
    end
    for (int ep = 0; ep < tot; ep++) begin
      s = init;
      stp = 0;
      ep_end = 1'b0;
      while (!ep_end) begin
        term = (term_at != 0 && stp + 1 == term_at) || ($urandom_range(99, 0) < term_pct);
        if (poke && ep == 0 && stp == 0) start = 1'b1;
        do_step(s, ep, term, dmin, dmax, ns);
        start = 1'b0;
        stp++;
        nsteps++;
        ep_end = term || (maxs != 0 && stp == maxs);
        s = ns;
      end
    end
    if (tot != 0) begin
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("final_iter", iteration, tot);
      chk("busy_in_fin", busy, 1);
    end
    @(negedge clk);
    chk("done_low", done, 0);
    chk("busy_after", busy, 0);
    chk("iter_hold", iteration, tot);
    chk("env_handshakes", env_hs - hs0, nsteps);
    chk("done_count", done_cnt - dn0, 1);
  endtask

  initial begin
    logic [5:0] ns;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    total_iteration = '0;
    max_steps = '0;
    init_state = '0;
    ad_act = '0;
    env_ack = 1'b0;
    env_next_state = '0;
    env_reward = '0;
    env_terminal = 1'b0;
    upd_ack = 1'b0;
    for (int i = 0; i < 256; i++) qtab[i] = $urandom;
    qtab[20] = -32'sd3;
    qtab[21] = 32'sd7;
    qtab[22] = 32'sd7;
    qtab[23] = -32'sd10;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_iter", iteration, 0);
    chk("rst_env_req", env_req, 0);
    chk("rst_upd_req", upd_req, 0);
    chk("rst_rd_en", q_rd_en, 0);
    chk("rst_qmax", ad_qmax, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(1, 0, 6'd5, 2, 0, 10, 10, 1'b1);
    run(3, 4, 6'd17, 0, 0, 0, 3, 1'b0);
    run(0, 5, 6'd3, 0, 0, 0, 0, 1'b0);
    run(4, 3, 6'($urandom), 0, 30, 0, 2, 1'b0);
    run(2, 0, 6'($urandom), 0, 50, 0, 1, 1'b0);

    // reset in the middle of an environment handshake
    total_iteration = 12'd2;
    max_steps = 8'd1;
    init_state = 6'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_step(6'd9, 0, 1'b0, 0, 1, ns);
    n = 0;
    while (env_req !== 1'b1 && n < 50) begin
      ad_act = 2'($urandom);
      @(negedge clk);
      n++;
    end
    chk("pre_rst_env_req", env_req, 1);
    chk("pre_rst_iter", iteration, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_env_req", env_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_iter", iteration, 0);
    chk("mid_rst_env_act", env_act, 0);
    rst_n = 1'b1;
    env_ack = 1'b1;
    @(negedge clk);
    env_ack = 1'b0;
    repeat (4) begin
      chk("post_rst_env_req", env_req, 0);
      chk("post_rst_upd_req", upd_req, 0);
      chk("post_rst_rd_en", q_rd_en, 0);
      chk("post_rst_busy", busy, 0);
      @(negedge clk);
    end
    run(2, 2, 6'd40, 0, 0, 0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
